// File: rtl/variable_latency_bank_adapter.sv
// Target-side adapter: turns req/gnt + vld/rdy traffic into a fixed-latency SRAM port.
// Read responses are credit-protected and buffered in a fall-through response FIFO.
module variable_latency_bank_adapter #(
  parameter int NumIn        = 32,
  parameter int IniAddWidth  = $clog2(NumIn),
  parameter int DataWidth    = 32,
  parameter int BeWidth      = DataWidth / 8,
  parameter int AddrMemWidth = 12,
  parameter int MemLatency   = 1,
  parameter int RespDepth    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [IniAddWidth-1:0]  ini_add_i,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic                    vld_o,
  input  logic                    rdy_i,
  output logic [IniAddWidth-1:0]  ini_add_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    mem_req_o,
  output logic [AddrMemWidth-1:0] mem_add_o,
  output logic                    mem_wen_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [BeWidth-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int EntryW = IniAddWidth + DataWidth;
  localparam int PtrW   = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int CntW   = $clog2(RespDepth + 1);
  localparam logic [CntW-1:0] DEPTH_C    = CntW'(RespDepth);
  localparam logic [CntW-1:0] CNT_ONE_C  = CntW'(1);
  localparam logic [PtrW-1:0] PTR_ONE_C  = PtrW'(1);
  localparam logic [PtrW-1:0] LAST_PTR_C = PtrW'(RespDepth - 1);

  if ((MemLatency < 1) || (MemLatency > 4) || (RespDepth < 1)) begin : g_param_err
    $fatal(1, "variable_latency_bank_adapter: MemLatency must be 1..4 and RespDepth >= 1");
  end

  logic [MemLatency-1:0]                  tag_vld_r;
  logic [MemLatency-1:0][IniAddWidth-1:0] tag_ini_r;
  logic [RespDepth-1:0][EntryW-1:0]       fifo_mem_r;
  logic [PtrW-1:0]                        wr_ptr_r;
  logic [PtrW-1:0]                        rd_ptr_r;
  logic [CntW-1:0]                        fifo_cnt_r;
  logic [CntW-1:0]                        credits_used_r;
  logic                                   accept_s;
  logic                                   rd_accept_s;
  logic                                   tag_arrive_s;
  logic                                   fifo_empty_s;
  logic                                   fifo_full_s;
  logic                                   push_s;
  logic                                   pop_s;
  logic                                   resp_hs_s;
  logic [EntryW-1:0]                      head_s;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    logic [PtrW-1:0] n;
    if (p == LAST_PTR_C) begin
      n = '0;
    end else begin
      n = p + PTR_ONE_C;
    end
    return n;
  endfunction

  // Grant depends only on registered credits, so rdy_i never reaches gnt_o.
  assign gnt_o        = !rst_i && (wen_i || (credits_used_r < DEPTH_C));
  assign accept_s     = req_i && gnt_o;
  assign rd_accept_s  = accept_s && !wen_i;

  assign mem_req_o    = accept_s;
  assign mem_add_o    = add_i;
  assign mem_wen_o    = wen_i;
  assign mem_wdata_o  = wdata_i;
  assign mem_be_o     = be_i;

  assign tag_arrive_s = tag_vld_r[MemLatency-1];
  assign fifo_empty_s = (fifo_cnt_r == '0);
  assign fifo_full_s  = (fifo_cnt_r == DEPTH_C);
  assign head_s       = fifo_mem_r[rd_ptr_r];

  // An arriving tag is stored unless it bypasses an empty FIFO straight into a ready sink.
  assign push_s       = !rst_i && tag_arrive_s && !(fifo_empty_s && rdy_i);
  assign pop_s        = !rst_i && !fifo_empty_s && rdy_i;
  assign resp_hs_s    = vld_o && rdy_i;

  // Response mux: FIFO head when occupied, otherwise the tag arriving from the SRAM.
  always_comb begin
    vld_o     = 1'b0;
    ini_add_o = head_s[EntryW-1 -: IniAddWidth];
    rdata_o   = head_s[DataWidth-1:0];
    if (rst_i) begin
      vld_o = 1'b0;
    end else if (!fifo_empty_s) begin
      vld_o = 1'b1;
    end else begin
      vld_o     = tag_arrive_s;
      ini_add_o = tag_ini_r[MemLatency-1];
      rdata_o   = mem_rdata_i;
    end
  end

  // Read tag pipeline aligned with the SRAM read latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld_r <= '0;
    end else begin
      tag_vld_r[0] <= rd_accept_s;
      tag_ini_r[0] <= ini_add_i;
      for (int i = 1; i < MemLatency; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_ini_r[i] <= tag_ini_r[i-1];
      end
    end
  end

  // Response FIFO storage, no reset needed on the payload.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {tag_ini_r[MemLatency-1], mem_rdata_i};
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE_C;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE_C;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Credits cover reads in the SRAM pipe plus FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_used_r <= '0;
    end else begin
      case ({rd_accept_s, resp_hs_s})
        2'b10:   credits_used_r <= credits_used_r + CNT_ONE_C;
        2'b01:   credits_used_r <= credits_used_r - CNT_ONE_C;
        default: credits_used_r <= credits_used_r;
      endcase
    end
  end

  variable_latency_bank_adapter_chk #(
    .CntW (CntW),
    .Depth(RespDepth)
  ) u_chk (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_s    (push_s),
    .full_s    (fifo_full_s),
    .credits_s (credits_used_r)
  );

endmodule

// Overflow guards for the response FIFO and credit counter.
module variable_latency_bank_adapter_chk #(
  parameter int CntW  = 2,
  parameter int Depth = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            push_s,
  input logic            full_s,
  input logic [CntW-1:0] credits_s
);

  localparam logic [CntW-1:0] DEPTH_C = CntW'(Depth);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_s && full_s));
  a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i) credits_s <= DEPTH_C);

endmodule

// File: tb/tb_variable_latency_bank_adapter.sv
// Directed bench: instance a (MemLatency 1, RespDepth 2) and instance b (MemLatency 2, RespDepth 3)
// each driven against a small behavioural SRAM model.
module tb_variable_latency_bank_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, wen, rdy;
  logic [4:0]  ini;
  logic [11:0] add;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        gnt_a, vld_a, mem_req_a, mem_wen_a;
  logic [4:0]  ini_a;
  logic [31:0] rdata_a, mem_wdata_a, rd_a;
  logic [11:0] mem_add_a;
  logic [3:0]  mem_be_a;

  logic        gnt_b, vld_b, mem_req_b, mem_wen_b;
  logic [4:0]  ini_b;
  logic [31:0] rdata_b, mem_wdata_b, rd_b1, rd_b2;
  logic [11:0] mem_add_b;
  logic [3:0]  mem_be_b;

  logic [31:0] mem_a [4096];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  variable_latency_bank_adapter #(.MemLatency(1), .RespDepth(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .ini_add_i(ini), .add_i(add),
    .wen_i(wen), .wdata_i(wdata), .be_i(be), .vld_o(vld_a), .rdy_i(rdy), .ini_add_o(ini_a),
    .rdata_o(rdata_a), .mem_req_o(mem_req_a), .mem_add_o(mem_add_a), .mem_wen_o(mem_wen_a),
    .mem_wdata_o(mem_wdata_a), .mem_be_o(mem_be_a), .mem_rdata_i(rd_a));

  variable_latency_bank_adapter #(.MemLatency(2), .RespDepth(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .ini_add_i(ini), .add_i(add),
    .wen_i(wen), .wdata_i(wdata), .be_i(be), .vld_o(vld_b), .rdy_i(rdy), .ini_add_o(ini_b),
    .rdata_o(rdata_b), .mem_req_o(mem_req_b), .mem_add_o(mem_add_b), .mem_wen_o(mem_wen_b),
    .mem_wdata_o(mem_wdata_b), .mem_be_o(mem_be_b), .mem_rdata_i(rd_b2));

  function automatic logic [31:0] init_word(input logic [11:0] a);
    if (a == 12'h010) return 32'hCAFEF00D;
    else return 32'h5A5A0000 + {20'd0, a};
  endfunction

  // SRAM models: a has latency 1 with byte-enabled writes, b is read-only with latency 2.
  always @(posedge clk) begin
    rd_a  <= mem_a[mem_add_a];
    rd_b1 <= init_word(mem_add_b);
    rd_b2 <= rd_b1;
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem_a[i] <= init_word(12'(i));
    end else if (mem_req_a && mem_wen_a) begin
      for (int i = 0; i < 4; i++)
        if (mem_be_a[i]) mem_a[mem_add_a][8*i +: 8] <= mem_wdata_a[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic resp_a(input string tag, input logic [4:0] id, input logic [31:0] d);
    check({tag, "_vld"}, 32'(vld_a), 32'd1);
    check({tag, "_ini"}, 32'(ini_a), 32'(id));
    check({tag, "_rdata"}, rdata_a, d);
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b1; req_b = 1'b0; wen = 1'b0; add = 12'h000; ini = 5'd0;
    wdata = 32'd0; be = 4'hF; rdy = 1'b1;
    next_cycle();
    // reset holds grant, response and strobe low even with req_i high
    for (int k = 0; k < 2; k++) begin
      mid();
      check("rst_gnt", 32'(gnt_a), 32'd0);
      check("rst_vld", 32'(vld_a), 32'd0);
      check("rst_mreq", 32'(mem_req_a), 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    mid();
    check("first_gnt", 32'(gnt_a), 32'd1);
    check("first_mreq", 32'(mem_req_a), 32'd1);
    check("first_vld0", 32'(vld_a), 32'd0);
    next_cycle(); req_a = 1'b0;
    mid(); resp_a("first_rsp", 5'd0, 32'h5A5A0000);
    next_cycle();

    // single read, latency 1
    req_a = 1'b1; add = 12'h010; ini = 5'd5;
    mid(); check("single_gnt", 32'(gnt_a), 32'd1); check("single_vld0", 32'(vld_a), 32'd0);
    next_cycle(); req_a = 1'b0;
    mid(); resp_a("single", 5'd5, 32'hCAFEF00D);
    next_cycle();

    // backpressure: two credits, then grant drops and the head holds
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_a = 1'b1; add = 12'h020 + 12'(k); ini = 5'(1 + k);
      mid();
      check("bp_gnt", 32'(gnt_a), (k < 2) ? 32'd1 : 32'd0);
      if (k >= 1) resp_a("bp_hold", 5'd1, 32'h5A5A0020);
      next_cycle();
    end
    req_a = 1'b1; add = 12'h030; ini = 5'd7; rdy = 1'b1;
    mid(); check("bp_pop_gnt", 32'(gnt_a), 32'd0); resp_a("bp_d0", 5'd1, 32'h5A5A0020);
    next_cycle();
    mid(); check("bp_regnt", 32'(gnt_a), 32'd1); resp_a("bp_d1", 5'd2, 32'h5A5A0021);
    next_cycle(); req_a = 1'b0;
    mid(); resp_a("bp_d2", 5'd7, 32'h5A5A0030);
    next_cycle();

    // fill credits, then a read is refused and a write still goes through
    rdy = 1'b0; req_a = 1'b1; add = 12'h040; ini = 5'd8;
    mid(); check("fill_gnt0", 32'(gnt_a), 32'd1);
    next_cycle(); add = 12'h041; ini = 5'd9;
    mid(); check("fill_gnt1", 32'(gnt_a), 32'd1);
    next_cycle(); add = 12'h099; ini = 5'd1;
    mid(); check("full_rd_gnt", 32'(gnt_a), 32'd0);
    next_cycle();
    wen = 1'b1; add = 12'h050; wdata = 32'h12345678; be = 4'b0011; ini = 5'd0;
    mid();
    check("wr_gnt", 32'(gnt_a), 32'd1);
    check("wr_mreq", 32'(mem_req_a), 32'd1);
    check("wr_mwen", 32'(mem_wen_a), 32'd1);
    check("wr_mbe", 32'(mem_be_a), 32'h3);
    check("wr_mwdata", mem_wdata_a, 32'h12345678);
    check("wr_madd", 32'(mem_add_a), 32'h050);
    resp_a("wr_hold", 5'd8, 32'h5A5A0040);
    next_cycle(); req_a = 1'b0; wen = 1'b0; be = 4'hF; rdy = 1'b1;
    mid(); resp_a("full_d0", 5'd8, 32'h5A5A0040);
    next_cycle();
    mid(); resp_a("full_d1", 5'd9, 32'h5A5A0041);
    next_cycle(); req_a = 1'b1; add = 12'h050; ini = 5'd3;
    mid(); check("no_wr_rsp", 32'(vld_a), 32'd0); check("rdback_gnt", 32'(gnt_a), 32'd1);
    next_cycle(); req_a = 1'b0;
    mid(); resp_a("rdback", 5'd3, 32'h5A5A5678);
    next_cycle();

    // reset one cycle after a read accept discards it and frees all credits
    req_a = 1'b1; add = 12'h060; ini = 5'd6;
    mid(); check("mf_gnt", 32'(gnt_a), 32'd1);
    next_cycle(); req_a = 1'b0; rst = 1'b1;
    mid(); check("mf_rst_vld", 32'(vld_a), 32'd0); check("mf_rst_gnt", 32'(gnt_a), 32'd0);
    next_cycle(); rst = 1'b0; rdy = 1'b0; req_a = 1'b1; add = 12'h070; ini = 5'd10;
    mid(); check("mf_post_vld", 32'(vld_a), 32'd0); check("mf_gnt0", 32'(gnt_a), 32'd1);
    next_cycle(); add = 12'h071; ini = 5'd11;
    mid(); check("mf_gnt1", 32'(gnt_a), 32'd1); resp_a("mf_hold", 5'd10, 32'h5A5A0070);
    next_cycle(); add = 12'h072; ini = 5'd12;
    mid(); check("mf_gnt2", 32'(gnt_a), 32'd0);
    next_cycle(); req_a = 1'b0; rdy = 1'b1;
    mid(); resp_a("mf_d0", 5'd10, 32'h5A5A0070);
    next_cycle();
    mid(); resp_a("mf_d1", 5'd11, 32'h5A5A0071);
    next_cycle();
    mid(); check("mf_idle", 32'(vld_a), 32'd0);
    next_cycle();

    // back-to-back reads on instance b: latency 2, depth 3
    rdy = 1'b1;
    for (int k = 0; k < 18; k++) begin
      req_b = (k < 16); add = 12'h100 + 12'(k); ini = 5'(k);
      mid();
      if (k < 16) check("b2b_gnt", 32'(gnt_b), 32'd1);
      if (k < 2) begin
        check("b2b_vld0", 32'(vld_b), 32'd0);
      end else begin
        check("b2b_vld", 32'(vld_b), 32'd1);
        check("b2b_ini", 32'(ini_b), 32'(5'(k - 2)));
        check("b2b_rdata", rdata_b, 32'h5A5A0100 + 32'(k - 2));
      end
      next_cycle();
    end
    req_b = 1'b0;
    mid(); check("b2b_idle", 32'(vld_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
